// File: rtl/dds2note_pitch.sv
// DDS phase increment -> MIDI note + 14-bit pitch-wheel value.
// Successive-approximation search over the note2dds table, then an 8-bit restoring divide.

// Note-to-increment table: top-octave constants shifted down by octave; registered output.
module note2dds (
  input  logic        clk,
  input  logic [6:0]  addr,
  output logic [31:0] tval
);
  localparam int unsigned TW = 32;

  logic [3:0]    oct_c;
  logic [3:0]    semi_c;
  logic [TW-1:0] base_c;

  assign oct_c  = 4'(addr / 7'd12);
  assign semi_c = 4'(addr % 7'd12);

  always_comb begin
    base_c = '0;
    case (semi_c)
      4'd0:    base_c = 32'd719151;
      4'd1:    base_c = 32'd761914;
      4'd2:    base_c = 32'd807220;
      4'd3:    base_c = 32'd855220;
      4'd4:    base_c = 32'd906074;
      4'd5:    base_c = 32'd959952;
      4'd6:    base_c = 32'd1017034;
      4'd7:    base_c = 32'd1077510;
      4'd8:    base_c = 32'd1141582;
      4'd9:    base_c = 32'd1209464;
      4'd10:   base_c = 32'd1281382;
      4'd11:   base_c = 32'd1357577;
      default: base_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    tval <= base_c >> (4'd10 - oct_c);
  end
endmodule

module dds2note_pitch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adder,
  input  logic        start,
  output logic [6:0]  note,
  output logic [13:0] pitch,
  output logic        valid,
  output logic        busy,
  output logic        under,
  output logic        over
);
  localparam int unsigned AW = 32;
  localparam int unsigned NW = 7;
  localparam int unsigned FW = 8;
  localparam int unsigned PW = 14;
  localparam int unsigned MW = 18;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_T0       = 3'd1;
  localparam logic [2:0] S_PROBE    = 3'd2;
  localparam logic [2:0] S_FETCH_HI = 3'd3;
  localparam logic [2:0] S_DIV      = 3'd4;
  localparam logic [2:0] S_SCALE    = 3'd5;

  localparam logic [PW-1:0] PITCH_CTR = 14'd8192;
  localparam logic [NW-1:0] NOTE_MAX  = 7'd127;

  logic [2:0]    state, state_d;
  logic          phase, phase_d;
  logic [AW-1:0] a_q, a_q_d;
  logic [NW-1:0] addr, addr_d;
  logic [NW-1:0] n, n_d;
  logic [AW-1:0] lo_val, lo_val_d;
  logic [2:0]    bidx, bidx_d;
  logic [AW-1:0] den, den_d;
  logic [AW:0]   rem, rem_d;
  logic [FW-1:0] frac, frac_d;
  logic [2:0]    cnt, cnt_d;
  logic [NW-1:0] note_d;
  logic [PW-1:0] pitch_d;
  logic          valid_d, busy_d, under_d, over_d;

  logic [AW-1:0] tval;
  logic          take_c;
  logic [NW-1:0] n_sel_c;
  logic [AW-1:0] lo_sel_c;
  logic [AW:0]   rem_sh_c;
  logic [MW-1:0] prod_c;

  note2dds u_rom (
    .clk  (clk),
    .addr (addr),
    .tval (tval)
  );

  // A probe keeps the trial note whenever its table value does not exceed the input.
  assign take_c   = (tval <= a_q);
  assign n_sel_c  = take_c ? addr : n;
  assign lo_sel_c = take_c ? tval : lo_val;
  assign rem_sh_c = 33'({rem, 1'b0});
  assign prod_c   = MW'(frac) * 18'd683;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      phase  <= 1'b0;
      a_q    <= '0;
      addr   <= '0;
      n      <= '0;
      lo_val <= '0;
      bidx   <= '0;
      den    <= '0;
      rem    <= '0;
      frac   <= '0;
      cnt    <= '0;
      note   <= '0;
      pitch  <= PITCH_CTR;
      valid  <= 1'b0;
      busy   <= 1'b0;
      under  <= 1'b0;
      over   <= 1'b0;
    end else begin
      state  <= state_d;
      phase  <= phase_d;
      a_q    <= a_q_d;
      addr   <= addr_d;
      n      <= n_d;
      lo_val <= lo_val_d;
      bidx   <= bidx_d;
      den    <= den_d;
      rem    <= rem_d;
      frac   <= frac_d;
      cnt    <= cnt_d;
      note   <= note_d;
      pitch  <= pitch_d;
      valid  <= valid_d;
      busy   <= busy_d;
      under  <= under_d;
      over   <= over_d;
    end
  end

  // Table lookups take two cycles; phase marks the cycle in which tval is current.
  always_comb begin
    state_d  = state;
    phase_d  = phase;
    a_q_d    = a_q;
    addr_d   = addr;
    n_d      = n;
    lo_val_d = lo_val;
    bidx_d   = bidx;
    den_d    = den;
    rem_d    = rem;
    frac_d   = frac;
    cnt_d    = cnt;
    note_d   = note;
    pitch_d  = pitch;
    valid_d  = 1'b0;
    busy_d   = busy;
    under_d  = under;
    over_d   = over;

    case (state)
      S_IDLE: begin
        if (start) begin
          a_q_d   = adder;
          addr_d  = '0;
          phase_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_T0;
        end
      end
      S_T0: begin
        phase_d = ~phase;
        if (phase) begin
          phase_d = 1'b0;
          if (a_q < tval) begin
            note_d  = '0;
            pitch_d = PITCH_CTR;
            under_d = 1'b1;
            over_d  = 1'b0;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            n_d      = '0;
            lo_val_d = tval;
            bidx_d   = 3'd6;
            addr_d   = 7'd64;
            state_d  = S_PROBE;
          end
        end
      end
      S_PROBE: begin
        phase_d = ~phase;
        if (phase) begin
          phase_d  = 1'b0;
          n_d      = n_sel_c;
          lo_val_d = lo_sel_c;
          if (bidx != 3'd0) begin
            bidx_d = 3'(bidx - 3'd1);
            addr_d = n_sel_c | (7'd1 << 3'(bidx - 3'd1));
          end else if (n_sel_c == NOTE_MAX) begin
            note_d  = NOTE_MAX;
            pitch_d = PITCH_CTR;
            under_d = 1'b0;
            over_d  = (a_q > lo_sel_c);
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            addr_d  = 7'(n_sel_c + 7'd1);
            state_d = S_FETCH_HI;
          end
        end
      end
      S_FETCH_HI: begin
        phase_d = ~phase;
        if (phase) begin
          phase_d = 1'b0;
          den_d   = tval - lo_val;
          rem_d   = {1'b0, a_q} - {1'b0, lo_val};
          frac_d  = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (rem_sh_c >= {1'b0, den}) begin
          rem_d  = rem_sh_c - {1'b0, den};
          frac_d = {frac[FW-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh_c;
          frac_d = {frac[FW-2:0], 1'b0};
        end
        cnt_d = 3'(cnt + 3'd1);
        if (cnt == 3'd7) begin
          state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        note_d  = n;
        pitch_d = PITCH_CTR + PW'(prod_c[MW-1:FW]);
        under_d = 1'b0;
        over_d  = 1'b0;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_dds2note_pitch.sv
// Scoreboard bench for dds2note_pitch: golden model by linear table search and exact division.
module tb_dds2note_pitch;
  logic        clk;
  logic        rst_n;
  logic [31:0] adder;
  logic        start;
  logic [6:0]  note;
  logic [13:0] pitch;
  logic        valid, busy, under, over;

  typedef struct {
    logic [6:0]  note;
    logic [13:0] pitch;
    logic        under;
    logic        over;
    int          lat;
    int          c0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  longint base_tab [12] = '{719151, 761914, 807220, 855220, 906074, 959952,
                            1017034, 1077510, 1141582, 1209464, 1281382, 1357577};

  dds2note_pitch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .adder (adder),
    .start (start),
    .note  (note),
    .pitch (pitch),
    .valid (valid),
    .busy  (busy),
    .under (under),
    .over  (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint t_of(input int n);
    return base_tab[n % 12] >> (10 - n / 12);
  endfunction

  function automatic exp_t golden(input logic [31:0] a);
    exp_t   e;
    int     n;
    longint av, frac;
    av = longint'(a);
    e.c0 = 0;
    e.under = 1'b0;
    e.over  = 1'b0;
    if (av < t_of(0)) begin
      e.note = 7'd0; e.pitch = 14'd8192; e.under = 1'b1; e.lat = 2;
      return e;
    end
    n = 0;
    for (int i = 0; i < 128; i++) if (t_of(i) <= av) n = i;
    e.note = 7'(n);
    if (n == 127) begin
      e.pitch = 14'd8192; e.over = (av > t_of(127)); e.lat = 16;
    end else begin
      frac = ((av - t_of(n)) * 256) / (t_of(n + 1) - t_of(n));
      e.pitch = 14'(8192 + ((frac * 683) >> 8));
      e.lat = 27;
    end
    return e;
  endfunction

  // Output side of the scoreboard: every valid pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("note", note, mon_e.note);
        check("pitch", pitch, mon_e.pitch);
        check("under", under, mon_e.under);
        check("over", over, mon_e.over);
        check("latency", cyc - mon_e.c0, mon_e.lat);
        check("busy_at_valid", busy, 0);
      end
    end
  end

  task automatic convert(input logic [31:0] a);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_start", busy, 0);
    e = golden(a);
    adder = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.c0 = cyc;
    exp_q.push_back(e);
    start = 1'b0;
    adder = $urandom;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_note"}, note, 0);
    check({tag, "_pitch"}, pitch, 8192);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_under"}, under, 0);
    check({tag, "_over"}, over, 0);
  endtask

  initial begin
    logic [31:0] a;
    longint      span;
    rst_n = 1'b0;
    start = 1'b0;
    adder = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed points, including table ends and interval midpoints.
    convert(32'(t_of(69)));                                   wait_done();
    convert(32'(t_of(60) + ((t_of(61) - t_of(60)) >> 1)));    wait_done();
    convert(32'(t_of(61) - 1));                               wait_done();
    convert(32'd0);                                           wait_done();
    convert(32'(t_of(0) - 1));                                wait_done();
    convert(32'(t_of(0)));                                    wait_done();
    convert(32'hFFFF_FFFF);                                   wait_done();
    convert(32'(t_of(127)));                                  wait_done();
    convert(32'(t_of(126) + 1));                              wait_done();

    // A second start mid-conversion and a changed adder must be ignored.
    convert(32'(t_of(45) + 7));
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    adder = 32'(t_of(100));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Reset asserted inside the divide loop aborts the conversion.
    convert(32'(t_of(30) + 3));
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    convert(32'(t_of(88) + 100));                             wait_done();

    // Random sweep across the whole table range.
    span = t_of(127) - t_of(0) + 1;
    for (int i = 0; i < 1000; i++) begin
      a = 32'(t_of(0) + (longint'($urandom) % span));
      convert(a);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
